// File: rtl/clock_bool_gen.sv
// rtl/clock_bool_gen.sv - synthesizes a slow clock boolean with one-cycle-early edge flags
module clock_bool_gen #(
  parameter int LEN_W     = 8,
  parameter int HIGH_DFLT = 2,
  parameter int LOW_DFLT  = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             LOAD,
  input  logic [LEN_W-1:0] HIGH_LEN,
  input  logic [LEN_W-1:0] LOW_LEN,
  output logic             CLK_VAL,
  output logic             PRE_RISE,
  output logic             PRE_FALL,
  output logic             RUNNING,
  output logic             PENDING
);

  localparam logic [LEN_W-1:0] ONE    = LEN_W'(1);
  localparam logic [LEN_W-1:0] HI_DEF = LEN_W'(HIGH_DFLT);
  localparam logic [LEN_W-1:0] LO_DEF = LEN_W'(LOW_DFLT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] act_hi_q, act_hi_d, act_lo_q, act_lo_d;
  logic [LEN_W-1:0] sh_hi_q, sh_hi_d, sh_lo_q, sh_lo_d;
  logic             pend_q, pend_d;
  logic             clk_val_q, running_q;
  logic             pre_rise, pre_fall, apply, cnt_zero;
  logic [LEN_W-1:0] next_hi;

  assign cnt_zero = (cnt_q == '0);
  // High length of the period about to start, including any pending shadow value
  assign next_hi  = pend_q ? sh_hi_q : act_hi_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    act_hi_d = act_hi_q;
    act_lo_d = act_lo_q;
    sh_hi_d  = sh_hi_q;
    sh_lo_d  = sh_lo_q;
    pend_d   = pend_q;
    pre_rise = 1'b0;
    pre_fall = 1'b0;
    apply    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        apply = pend_q;
        if (EN) begin
          pre_rise = 1'b1;
          state_d  = ST_HIGH;
          cnt_d    = next_hi - ONE;
        end
      end
      ST_HIGH: begin
        if (cnt_zero) begin
          pre_fall = 1'b1;
          state_d  = ST_LOW;
          cnt_d    = act_lo_q - ONE;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      ST_LOW: begin
        if (!EN) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_zero) begin
          pre_rise = 1'b1;
          apply    = pend_q;
          state_d  = ST_HIGH;
          cnt_d    = next_hi - ONE;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (apply) begin
      act_hi_d = sh_hi_q;
      act_lo_d = sh_lo_q;
      pend_d   = 1'b0;
    end
    // A LOAD coinciding with an apply lands in the shadow and stays pending
    if (LOAD) begin
      sh_hi_d = (HIGH_LEN == '0) ? ONE : HIGH_LEN;
      sh_lo_d = (LOW_LEN == '0) ? ONE : LOW_LEN;
      pend_d  = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      act_hi_q  <= HI_DEF;
      act_lo_q  <= LO_DEF;
      sh_hi_q   <= HI_DEF;
      sh_lo_q   <= LO_DEF;
      pend_q    <= 1'b0;
      clk_val_q <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      act_hi_q  <= act_hi_d;
      act_lo_q  <= act_lo_d;
      sh_hi_q   <= sh_hi_d;
      sh_lo_q   <= sh_lo_d;
      pend_q    <= pend_d;
      clk_val_q <= (state_d == ST_HIGH);
      running_q <= (state_d != ST_IDLE);
    end
  end

  assign CLK_VAL  = clk_val_q;
  assign RUNNING  = running_q;
  assign PENDING  = pend_q;
  assign PRE_RISE = pre_rise;
  assign PRE_FALL = pre_fall;

endmodule

// File: tb/tb_clock_bool_gen.sv
// tb/tb_clock_bool_gen.sv - randomized and directed bench for clock_bool_gen
module tb_clock_bool_gen;

  logic       CLK = 1'b0;
  logic       RST, EN, LOAD;
  logic [7:0] HIGH_LEN, LOW_LEN;
  logic       CLK_VAL, PRE_RISE, PRE_FALL, RUNNING, PENDING;

  int errors = 0;
  int checks = 0;

  // Reference model: position within the current period plus active/shadow lengths
  bit m_run, n_run, m_pend, n_pend;
  int m_pos, n_pos, m_hi, n_hi, m_lo, n_lo;
  int m_sh_hi, n_sh_hi, m_sh_lo, n_sh_lo;
  bit exp_clk, exp_rise, exp_fall, exp_run, exp_pend;

  clock_bool_gen #(.LEN_W(8), .HIGH_DFLT(2), .LOW_DFLT(2)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .LOAD(LOAD),
    .HIGH_LEN(HIGH_LEN), .LOW_LEN(LOW_LEN),
    .CLK_VAL(CLK_VAL), .PRE_RISE(PRE_RISE), .PRE_FALL(PRE_FALL),
    .RUNNING(RUNNING), .PENDING(PENDING)
  );

  always #5 CLK = ~CLK;

  task automatic drive(input bit rst, input bit en, input bit load, input int hl, input int ll);
    bit nclk;
    RST = rst; EN = en; LOAD = load; HIGH_LEN = 8'(hl); LOW_LEN = 8'(ll);
    #1;
    exp_clk  = m_run && (m_pos < m_hi);
    exp_run  = m_run;
    exp_pend = m_pend;
    n_run = m_run; n_pos = m_pos; n_hi = m_hi; n_lo = m_lo;
    n_sh_hi = m_sh_hi; n_sh_lo = m_sh_lo; n_pend = m_pend;
    if (rst) begin
      n_run = 0; n_pos = 0; n_hi = 2; n_lo = 2; n_sh_hi = 2; n_sh_lo = 2; n_pend = 0;
    end else begin
      if (!m_run) begin
        if (m_pend) begin n_hi = m_sh_hi; n_lo = m_sh_lo; n_pend = 0; end
        if (en) begin n_run = 1; n_pos = 0; end
      end else if (m_pos < m_hi) begin
        n_pos = m_pos + 1;
      end else if (!en) begin
        n_run = 0; n_pos = 0;
      end else if (m_pos == m_hi + m_lo - 1) begin
        n_pos = 0;
        if (m_pend) begin n_hi = m_sh_hi; n_lo = m_sh_lo; n_pend = 0; end
      end else begin
        n_pos = m_pos + 1;
      end
      if (load) begin
        n_sh_hi = (hl % 256 == 0) ? 1 : hl % 256;
        n_sh_lo = (ll % 256 == 0) ? 1 : ll % 256;
        n_pend  = 1;
      end
    end
    nclk     = n_run && (n_pos < n_hi);
    exp_rise = !exp_clk && nclk;
    exp_fall = exp_clk && !nclk;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    m_run = n_run; m_pos = n_pos; m_hi = n_hi; m_lo = n_lo;
    m_sh_hi = n_sh_hi; m_sh_lo = n_sh_lo; m_pend = n_pend;
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0); tick();
  endtask

  task automatic test_reset();
    drive(1, 1, 1, 7, 7); tick();
    drive(1, 1, 1, 7, 7); tick();
    drive(0, 0, 0, 0, 0);
    checks++; if (CLK_VAL !== 1'b0) begin errors++; $display("FAIL reset_clk_val got %b want 0", CLK_VAL); end
    checks++; if (RUNNING !== 1'b0) begin errors++; $display("FAIL reset_running got %b want 0", RUNNING); end
    checks++; if (PENDING !== 1'b0) begin errors++; $display("FAIL reset_pending got %b want 0", PENDING); end
    checks++; if ({PRE_RISE, PRE_FALL} !== 2'b00) begin errors++; $display("FAIL reset_pre got %b want 00", {PRE_RISE, PRE_FALL}); end
    tick();
  endtask

  task automatic test_defaults();
    bit pat [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    for (int i = 0; i < 13; i++) begin
      drive(0, 1, 0, 0, 0);
      checks++;
      if ({CLK_VAL, PRE_RISE, PRE_FALL, RUNNING, PENDING} !== {exp_clk, exp_rise, exp_fall, exp_run, exp_pend}) begin
        errors++;
        $display("FAIL defaults_model cyc %0d got %b want %b", i, {CLK_VAL, PRE_RISE, PRE_FALL, RUNNING, PENDING}, {exp_clk, exp_rise, exp_fall, exp_run, exp_pend});
      end
      checks++;
      if (CLK_VAL !== ((i == 0) ? 1'b0 : pat[(i - 1) % 4])) begin
        errors++; $display("FAIL defaults_wave cyc %0d got %b want %b", i, CLK_VAL, (i == 0) ? 1'b0 : pat[(i - 1) % 4]);
      end
      tick();
    end
  endtask

  task automatic test_load_mid_high();
    int highs[$], lows[$];
    int run = 0;
    bit prev = 1'b1;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(0, 1, (i == 1), 3, 1);
      checks++;
      if ({CLK_VAL, PRE_RISE, PRE_FALL, RUNNING, PENDING} !== {exp_clk, exp_rise, exp_fall, exp_run, exp_pend}) begin
        errors++;
        $display("FAIL load_mid_model cyc %0d got %b want %b", i, {CLK_VAL, PRE_RISE, PRE_FALL, RUNNING, PENDING}, {exp_clk, exp_rise, exp_fall, exp_run, exp_pend});
      end
      if (i >= 1) begin
        if (CLK_VAL === prev) run++;
        else begin
          if (prev) highs.push_back(run); else lows.push_back(run);
          prev = CLK_VAL; run = 1;
        end
      end
      tick();
    end
    checks++;
    if (highs.size() < 3 || lows.size() < 2 || highs[0] != 2 || highs[1] != 3 || highs[2] != 3 || lows[0] != 2 || lows[1] != 1) begin
      errors++; $display("FAIL load_mid_runs got highs=%p lows=%p want highs 2,3,3 lows 2,1", highs, lows);
    end
  endtask

  task automatic test_load_pre_rise();
    int highs[$], lows[$];
    int run = 0;
    bit prev = 1'b1;
    do_reset();
    for (int i = 0; i < 15; i++) begin
      drive(0, 1, (i == 4), 1, 1);
      checks++;
      if ({CLK_VAL, PRE_RISE, PRE_FALL, RUNNING, PENDING} !== {exp_clk, exp_rise, exp_fall, exp_run, exp_pend}) begin
        errors++;
        $display("FAIL load_rise_model cyc %0d got %b want %b", i, {CLK_VAL, PRE_RISE, PRE_FALL, RUNNING, PENDING}, {exp_clk, exp_rise, exp_fall, exp_run, exp_pend});
      end
      if (i == 4) begin
        checks++; if (PRE_RISE !== 1'b1) begin errors++; $display("FAIL load_rise_strobe got %b want 1", PRE_RISE); end
      end
      if (i >= 1) begin
        if (CLK_VAL === prev) run++;
        else begin
          if (prev) highs.push_back(run); else lows.push_back(run);
          prev = CLK_VAL; run = 1;
        end
      end
      tick();
    end
    checks++;
    if (highs.size() < 4 || lows.size() < 3 || highs[0] != 2 || highs[1] != 2 || highs[2] != 1 || highs[3] != 1 ||
        lows[0] != 2 || lows[1] != 2 || lows[2] != 1) begin
      errors++; $display("FAIL load_rise_runs got highs=%p lows=%p want highs 2,2,1,1 lows 2,2,1", highs, lows);
    end
  endtask

  task automatic test_en_drop();
    int n_high = 0, n_fall = 0, n_rise_late = 0;
    do_reset();
    for (int i = 0; i < 13; i++) begin
      drive(0, (i == 2 || i == 3), (i == 0), 4, 2);
      checks++;
      if ({CLK_VAL, PRE_RISE, PRE_FALL, RUNNING, PENDING} !== {exp_clk, exp_rise, exp_fall, exp_run, exp_pend}) begin
        errors++;
        $display("FAIL en_drop_model cyc %0d got %b want %b", i, {CLK_VAL, PRE_RISE, PRE_FALL, RUNNING, PENDING}, {exp_clk, exp_rise, exp_fall, exp_run, exp_pend});
      end
      if (CLK_VAL === 1'b1) n_high++;
      if (PRE_FALL === 1'b1) n_fall++;
      if (i > 2 && PRE_RISE === 1'b1) n_rise_late++;
      tick();
    end
    checks++; if (n_high != 4) begin errors++; $display("FAIL en_drop_high got %0d want 4", n_high); end
    checks++; if (n_fall != 1) begin errors++; $display("FAIL en_drop_fall got %0d want 1", n_fall); end
    checks++; if (n_rise_late != 0) begin errors++; $display("FAIL en_drop_rise got %0d want 0", n_rise_late); end
    checks++; if (RUNNING !== 1'b0) begin errors++; $display("FAIL en_drop_running got %b want 0", RUNNING); end
  endtask

  task automatic test_zero_clamp();
    do_reset();
    for (int i = 0; i < 14; i++) begin
      drive(0, (i >= 2), (i == 0), 0, 0);
      checks++;
      if ({CLK_VAL, PRE_RISE, PRE_FALL, RUNNING, PENDING} !== {exp_clk, exp_rise, exp_fall, exp_run, exp_pend}) begin
        errors++;
        $display("FAIL zero_model cyc %0d got %b want %b", i, {CLK_VAL, PRE_RISE, PRE_FALL, RUNNING, PENDING}, {exp_clk, exp_rise, exp_fall, exp_run, exp_pend});
      end
      if (i >= 3) begin
        checks++;
        if (CLK_VAL !== ((i - 3) % 2 == 0)) begin errors++; $display("FAIL zero_toggle cyc %0d got %b want %b", i, CLK_VAL, (i - 3) % 2 == 0); end
      end
      if (i >= 2) begin
        checks++;
        if ((PRE_RISE ^ PRE_FALL) !== 1'b1) begin errors++; $display("FAIL zero_alt cyc %0d got %b%b want one-hot", i, PRE_RISE, PRE_FALL); end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_high();
    int highs[$];
    int run = 0;
    do_reset();
    drive(0, 1, 0, 0, 0); tick();
    drive(1, 1, 1, 5, 5); tick();
    drive(0, 0, 0, 0, 0);
    checks++;
    if ({CLK_VAL, RUNNING, PENDING} !== 3'b000) begin
      errors++; $display("FAIL rst_mid_state got %b want 000", {CLK_VAL, RUNNING, PENDING});
    end
    tick();
    for (int i = 0; i < 9; i++) begin
      drive(0, 1, 0, 0, 0);
      checks++;
      if ({CLK_VAL, PRE_RISE, PRE_FALL, RUNNING, PENDING} !== {exp_clk, exp_rise, exp_fall, exp_run, exp_pend}) begin
        errors++;
        $display("FAIL rst_mid_model cyc %0d got %b want %b", i, {CLK_VAL, PRE_RISE, PRE_FALL, RUNNING, PENDING}, {exp_clk, exp_rise, exp_fall, exp_run, exp_pend});
      end
      if (CLK_VAL === 1'b1) run++;
      else if (run != 0) begin highs.push_back(run); run = 0; end
      tick();
    end
    checks++;
    if (highs.size() < 2 || highs[0] != 2 || highs[1] != 2) begin
      errors++; $display("FAIL rst_mid_lengths got highs=%p want 2,2", highs);
    end
  endtask

  task automatic test_random();
    bit rst, en, ld;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom % 200) == 0;
      en  = ($urandom % 8) != 0;
      ld  = ($urandom % 10) == 0;
      drive(rst, en, ld, $urandom_range(0, 5), $urandom_range(0, 5));
      if (!rst) begin
        checks++;
        if ({CLK_VAL, PRE_RISE, PRE_FALL, RUNNING, PENDING} !== {exp_clk, exp_rise, exp_fall, exp_run, exp_pend}) begin
          errors++;
          $display("FAIL random_model cyc %0d got %b want %b", i, {CLK_VAL, PRE_RISE, PRE_FALL, RUNNING, PENDING}, {exp_clk, exp_rise, exp_fall, exp_run, exp_pend});
        end
        checks++;
        if ((PRE_RISE & PRE_FALL) !== 1'b0) begin errors++; $display("FAIL random_both cyc %0d got 1 want 0", i); end
      end
      tick();
    end
  endtask

  initial begin
    RST = 1'b1; EN = 1'b0; LOAD = 1'b0; HIGH_LEN = '0; LOW_LEN = '0;
    test_reset();
    test_defaults();
    test_load_mid_high();
    test_load_pre_rise();
    test_en_drop();
    test_zero_clamp();
    test_reset_mid_high();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
